diff_frame_ctrl: RTL and testbench
==================================

Name: diff_frame_ctrl

Overview:
Frame-level sequencer for the frame-difference motion datapath. Rotates three frame-buffer banks (write / current / previous) on every camera frame and suppresses diff output until two full frames are stored. It latches the pixel-difference threshold per frame and counts motion pixels from the diff stage. It then raises a debounced motion flag. Sits between the camera capture/SDRAM arbiter and the diff stage, and drives the alarm/overlay logic.

Parameters:
IMG_W, 640, active pixels per line
IMG_H, 480, active lines per frame
HOLD_FRAMES, 30, frames motion_flag stays high after last motion frame
CNT_W, 20, width of pixel counters (must hold IMG_W*IMG_H)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = run sequencer; 0 = return to IDLE at next frame start
cam_vsync  in  1  capture-side vsync; rising edge = frame start
threshold_in  in  8  requested diff threshold
alarm_cnt  in  CNT_W  motion pixel count that triggers alarm
diff_vsync  in  1  post_frame_vsync from diff stage
diff_href  in  1  post_frame_href from diff stage
diff_clken  in  1  post_frame_clken from diff stage
diff_bit  in  8  diff result, 8'hFF = motion pixel, 8'h00 = static
wr_bank  out  2  bank receiving the incoming frame (0..2)
rd_cur_bank  out  2  bank read as data_cur
rd_prev_bank  out  2  bank read as data_next
threshold  out  8  threshold applied to diff stage for this frame
diff_valid  out  1  1 = diff stage output is meaningful this frame
frame_done  out  1  one-cycle pulse after end-of-frame evaluation
motion_cnt  out  CNT_W  motion pixels in last evaluated frame
frame_err  out  1  last evaluated frame pixel count != IMG_W*IMG_H
motion_flag  out  1  debounced motion alarm

Behaviour:
- Reset values:
  - wr_bank=0, rd_cur_bank=2, rd_prev_bank=1, threshold=0, diff_valid=0, frame_done=0, motion_cnt=0, frame_err=0, motion_flag=0, hold counter=0, state=IDLE.
- Edge detection: cam_vsync and diff_vsync are registered once. Rise/fall are detected against the registered copy, so each event is seen 1 cycle after the input edge.
- Frame start (cam_vsync rise), actions in the same cycle:
  - threshold <= threshold_in. Threshold stays constant for the whole frame; mid-frame changes to threshold_in are ignored.
  - Banks rotate: wr_bank <= (wr_bank+1) mod 3, rd_cur_bank <= old wr_bank, rd_prev_bank <= old rd_cur_bank. The three outputs are always pairwise distinct.
- States:
  - IDLE: no rotation, diff_valid=0. At a frame start with enable=1, go to FILL0 and rotate.
  - FILL0: first frame written. At the next frame start, go to FILL1 and rotate.
  - FILL1: second frame written; cur is valid, prev is not. At the next frame start, go to RUN, rotate, and set diff_valid=1.
  - RUN: diff_valid=1. At a frame start with enable=0, go to IDLE with diff_valid=0 and no rotation.
  - Any state: enable=0 takes effect only at a frame start, never mid-frame.
- Counting, in RUN with diff_valid=1:
  - Pixel counter increments on diff_clken&diff_href.
  - Motion counter increments when diff_clken&diff_href&(diff_bit==8'hFF). Any other diff_bit value is not motion.
  - Both counters saturate at all-ones.
  - Both counters clear on diff_vsync rise.
- End of frame (diff_vsync fall, RUN only):
  - motion_cnt <= motion counter.
  - frame_err <= (pixel counter != IMG_W*IMG_H).
  - If motion counter >= alarm_cnt and frame_err would be 0: motion_flag <= 1 and hold <= HOLD_FRAMES.
  - Otherwise, if hold > 0: hold <= hold-1. motion_flag <= 0 when hold reaches 0 (i.e. when hold==1 is decremented).
  - An errored frame never triggers an alarm but still decrements hold.
  - frame_done pulses 1 cycle, 1 cycle after the outputs update.
- alarm_cnt=0: every error-free RUN frame triggers.
- Simultaneous cam_vsync rise and diff_vsync fall in the same cycle: both are processed independently. Rotation and evaluation do not interact.
- diff_vsync edges outside RUN are ignored: no frame_done, motion_cnt holds.
- rst_n low at any time: asynchronous return to reset values, including mid-frame. After release, a frame start is required before anything happens.

Test Plan:
- Reset then enable=1 with 4 frames of 640x480, diff_bit=0 -> banks (w,c,p) go (1,0,2),(2,1,0),(0,2,1),(1,0,2); diff_valid=1 only from 3rd frame start; frame_done pulses on 3rd and 4th frame ends.
- RUN, alarm_cnt=100, frame with 150 pixels of 8'hFF -> motion_cnt=150, motion_flag=1; then HOLD_FRAMES=3 (override) static frames -> flag falls exactly at end of 3rd static frame.
- Frame with exactly 100 motion pixels, alarm_cnt=100 -> triggers. Frame with 99 -> no trigger. Frame with diff_bit=8'h80 everywhere -> motion_cnt=0.
- Short frame (640x479 pixels) with 10000 motion pixels -> frame_err=1, motion_flag unchanged, hold decremented.
- threshold_in changed 20->60 mid-frame -> threshold stays 20 until next cam_vsync rise, then 60.
- enable dropped mid-frame in RUN -> no effect until next frame start, then IDLE, diff_valid=0, banks frozen. rst_n pulsed mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/diff_frame_ctrl_if.sv
// rtl/diff_frame_ctrl_if.sv - capture/diff-stage side signals of the frame sequencer
interface diff_frame_ctrl_if #(
  parameter int CNT_W = 20
);
  logic             enable;
  logic             cam_vsync;
  logic [7:0]       threshold_in;
  logic [CNT_W-1:0] alarm_cnt;
  logic             diff_vsync;
  logic             diff_href;
  logic             diff_clken;
  logic [7:0]       diff_bit;
  logic [1:0]       wr_bank;
  logic [1:0]       rd_cur_bank;
  logic [1:0]       rd_prev_bank;
  logic [7:0]       threshold;
  logic             diff_valid;
  logic             frame_done;
  logic [CNT_W-1:0] motion_cnt;
  logic             frame_err;
  logic             motion_flag;

  modport master (
    output enable, cam_vsync, threshold_in, alarm_cnt,
           diff_vsync, diff_href, diff_clken, diff_bit,
    input  wr_bank, rd_cur_bank, rd_prev_bank, threshold, diff_valid,
           frame_done, motion_cnt, frame_err, motion_flag
  );

  modport slave (
    input  enable, cam_vsync, threshold_in, alarm_cnt,
           diff_vsync, diff_href, diff_clken, diff_bit,
    output wr_bank, rd_cur_bank, rd_prev_bank, threshold, diff_valid,
           frame_done, motion_cnt, frame_err, motion_flag
  );
endinterface

// File: rtl/diff_frame_ctrl.sv
// rtl/diff_frame_ctrl.sv - frame bank rotation, threshold latch and debounced motion alarm
module diff_frame_ctrl #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int HOLD_FRAMES = 30,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  diff_frame_ctrl_if.slave bus
);

  localparam int               HOLD_W    = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_V   = HOLD_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL0,
    S_FILL1,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cam_vs;
  logic              r_diff_vs;
  logic [1:0]        r_wr_bank;
  logic [1:0]        r_cur_bank;
  logic [1:0]        r_prev_bank;
  logic [7:0]        r_threshold;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0]  r_mot_cnt;
  logic [CNT_W-1:0]  r_motion_cnt;
  logic              r_frame_err;
  logic              r_motion_flag;
  logic [HOLD_W-1:0] r_hold;
  logic              r_eval_q;
  logic              r_frame_done;

  logic w_cam_rise;
  logic w_diff_rise;
  logic w_diff_fall;
  logic w_run;
  logic w_rotate;
  logic w_pix_hit;
  logic w_mot_hit;
  logic w_eval;
  logic w_pix_ok;
  logic w_trigger;

  assign w_cam_rise  = bus.cam_vsync & ~r_cam_vs;
  assign w_diff_rise = bus.diff_vsync & ~r_diff_vs;
  assign w_diff_fall = ~bus.diff_vsync & r_diff_vs;
  assign w_run       = (r_state == S_RUN);
  // enable=0 at a frame start parks the sequencer without touching the banks
  assign w_rotate    = w_cam_rise & bus.enable;
  assign w_pix_hit   = w_run & bus.diff_clken & bus.diff_href;
  assign w_mot_hit   = w_pix_hit & (bus.diff_bit == 8'hFF);
  assign w_eval      = w_run & w_diff_fall;
  assign w_pix_ok    = (r_pix_cnt == FRAME_PIX);
  assign w_trigger   = w_pix_ok & (r_mot_cnt >= bus.alarm_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cam_rise) begin
      if (!bus.enable) begin
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  w_state_nxt = S_FILL0;
          S_FILL0: w_state_nxt = S_FILL1;
          S_FILL1: w_state_nxt = S_RUN;
          default: w_state_nxt = S_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cam_vs    <= 1'b0;
      r_diff_vs   <= 1'b0;
      r_wr_bank   <= 2'd0;
      r_cur_bank  <= 2'd2;
      r_prev_bank <= 2'd1;
      r_threshold <= 8'd0;
    end else begin
      r_cam_vs  <= bus.cam_vsync;
      r_diff_vs <= bus.diff_vsync;
      if (w_cam_rise) begin
        r_threshold <= bus.threshold_in;
      end
      if (w_rotate) begin
        r_wr_bank   <= (r_wr_bank == 2'd2) ? 2'd0 : r_wr_bank + 2'd1;
        r_cur_bank  <= r_wr_bank;
        r_prev_bank <= r_cur_bank;
      end
    end
  end

  // Counters saturate so an overlong frame still reads as errored, never wraps to "ok"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
      r_mot_cnt <= '0;
    end else if (w_diff_rise) begin
      r_pix_cnt <= '0;
      r_mot_cnt <= '0;
    end else begin
      if (w_pix_hit && (r_pix_cnt != '1)) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      if (w_mot_hit && (r_mot_cnt != '1)) begin
        r_mot_cnt <= r_mot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_motion_cnt  <= '0;
      r_frame_err   <= 1'b0;
      r_motion_flag <= 1'b0;
      r_hold        <= '0;
      r_eval_q      <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_eval_q     <= w_eval;
      r_frame_done <= r_eval_q;
      if (w_eval) begin
        r_motion_cnt <= r_mot_cnt;
        r_frame_err  <= ~w_pix_ok;
        if (w_trigger) begin
          r_motion_flag <= 1'b1;
          r_hold        <= HOLD_V;
        end else if (r_hold != '0) begin
          r_hold <= r_hold - 1'b1;
          if (r_hold == HOLD_W'(1)) begin
            r_motion_flag <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.wr_bank      = r_wr_bank;
  assign bus.rd_cur_bank  = r_cur_bank;
  assign bus.rd_prev_bank = r_prev_bank;
  assign bus.threshold    = r_threshold;
  assign bus.diff_valid   = w_run;
  assign bus.frame_done   = r_frame_done;
  assign bus.motion_cnt   = r_motion_cnt;
  assign bus.frame_err    = r_frame_err;
  assign bus.motion_flag  = r_motion_flag;

endmodule

// File: tb/tb_diff_frame_ctrl.sv
// tb/tb_diff_frame_ctrl.sv - scoreboard bench for diff_frame_ctrl on a small frame
module tb_diff_frame_ctrl;
  localparam int W    = 20;
  localparam int H    = 12;
  localparam int HOLD = 3;
  localparam int CW   = 8;
  localparam int FP   = W * H;
  localparam int SAT  = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  diff_frame_ctrl_if #(.CNT_W(CW)) bus ();

  diff_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .HOLD_FRAMES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int mc;
    int err;
    int flag;
  } exp_t;
  exp_t sb[$];

  // Model: frames since enable, rotation count, alarm hold in whole frames
  int m_filled = 0;
  int m_rot    = 0;
  int m_hold   = 0;
  int m_flag   = 0;
  int m_thr    = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_done_unexpected: got pulse expected none");
      end else begin
        e = sb.pop_front();
        chk("motion_cnt", int'(bus.motion_cnt), e.mc);
        chk("frame_err", int'(bus.frame_err), e.err);
        chk("motion_flag", int'(bus.motion_flag), e.flag);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_wr"}, int'(bus.wr_bank), 0);
    chk({tag, "_cur"}, int'(bus.rd_cur_bank), 2);
    chk({tag, "_prev"}, int'(bus.rd_prev_bank), 1);
    chk({tag, "_thr"}, int'(bus.threshold), 0);
    chk({tag, "_dv"}, int'(bus.diff_valid), 0);
    chk({tag, "_fd"}, int'(bus.frame_done), 0);
    chk({tag, "_mc"}, int'(bus.motion_cnt), 0);
    chk({tag, "_err"}, int'(bus.frame_err), 0);
    chk({tag, "_flag"}, int'(bus.motion_flag), 0);
  endtask

  task automatic chk_frame_state();
    chk("wr_bank", int'(bus.wr_bank), m_rot % 3);
    chk("rd_cur_bank", int'(bus.rd_cur_bank), (m_rot + 2) % 3);
    chk("rd_prev_bank", int'(bus.rd_prev_bank), (m_rot + 1) % 3);
    chk("diff_valid", int'(bus.diff_valid), (m_filled >= 3) ? 1 : 0);
    chk("threshold", int'(bus.threshold), m_thr);
  endtask

  task automatic model_start(input int thr);
    m_thr = thr;
    if (bus.enable) begin
      m_filled++;
      m_rot++;
    end else begin
      m_filled = 0;
    end
  endtask

  // other < 0: random non-motion byte; keep_diff leaves diff_vsync high so the
  // next frame start coincides with this frame's end
  task automatic run_frame(input int n_pix, input int n_mot, input int other,
                           input int thr0, input int thr1, input bit drop_en,
                           input bit keep_diff);
    int   rem_pix;
    int   rem_mot;
    bit   running;
    bit   is_mot;
    exp_t e;
    int   pc;
    bus.threshold_in = 8'(thr0);
    bus.cam_vsync = 1'b1;
    model_start(thr0);
    running = (m_filled >= 3);
    if (bus.diff_vsync) begin
      bus.diff_vsync = 1'b0;
      tick(2);
    end
    bus.diff_vsync = 1'b1;
    tick(3);
    chk_frame_state();
    rem_pix = n_pix;
    rem_mot = n_mot;
    for (int p = 0; p < n_pix; p++) begin
      if (p > 0 && (p % W) == 0) begin
        bus.diff_href  = 1'b0;
        bus.diff_clken = 1'($urandom);
        bus.diff_bit   = 8'hFF;
        tick(3);
      end
      if (p == n_pix / 2) begin
        if (thr1 >= 0) bus.threshold_in = 8'(thr1);
        if (drop_en) bus.enable = 1'b0;
      end
      if (($urandom % 4) == 0) begin
        bus.diff_href  = 1'b1;
        bus.diff_clken = 1'b0;
        bus.diff_bit   = 8'hFF;
        tick(1);
      end
      is_mot = ($urandom_range(0, rem_pix - 1) < rem_mot);
      bus.diff_href  = 1'b1;
      bus.diff_clken = 1'b1;
      if (is_mot) bus.diff_bit = 8'hFF;
      else if (other < 0) bus.diff_bit = 8'($urandom_range(0, 254));
      else bus.diff_bit = 8'(other);
      if (is_mot) rem_mot--;
      rem_pix--;
      tick(1);
    end
    bus.diff_href  = 1'b0;
    bus.diff_clken = 1'b0;
    tick(2);
    chk("threshold_hold", int'(bus.threshold), m_thr);
    if (running) begin
      e.mc = (n_mot > SAT) ? SAT : n_mot;
      pc   = (n_pix > SAT) ? SAT : n_pix;
      e.err = (pc != FP) ? 1 : 0;
      if (e.err == 0 && e.mc >= int'(bus.alarm_cnt)) begin
        m_flag = 1;
        m_hold = HOLD;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_flag = 0;
      end
      e.flag = m_flag;
      sb.push_back(e);
    end
    bus.cam_vsync = 1'b0;
    if (!keep_diff) begin
      bus.diff_vsync = 1'b0;
      tick(6);
      chk("sb_drain", sb.size(), 0);
    end else begin
      tick(3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    bus.enable = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.threshold_in = 8'd0;
    bus.alarm_cnt = 8'd100;
    bus.diff_vsync = 1'b0;
    bus.diff_href = 1'b0;
    bus.diff_clken = 1'b0;
    bus.diff_bit = 8'd0;
    tick(3);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(2);
    chk_reset("post_rst");

    bus.enable = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(FP, 0, 0, 10, -1, 0, 0);

    run_frame(FP, 150, -1, 10, -1, 0, 0);
    for (int f = 0; f < 3; f++) run_frame(FP, 0, 0, 10, -1, 0, 0);

    run_frame(FP, 100, -1, 10, -1, 0, 0);
    run_frame(FP, 99, -1, 10, -1, 0, 0);
    run_frame(FP, 0, 8'h80, 10, -1, 0, 0);

    run_frame(FP, 150, -1, 10, -1, 0, 0);
    run_frame(FP - W, 200, -1, 10, -1, 0, 0);
    run_frame(FP + W, FP + W, -1, 10, -1, 0, 0);

    run_frame(FP, 5, -1, 20, 60, 0, 0);
    run_frame(FP, 5, -1, 60, -1, 0, 0);

    run_frame(FP, 120, -1, 33, -1, 0, 1);
    run_frame(FP, 3, -1, 34, -1, 0, 0);

    bus.alarm_cnt = 8'd0;
    run_frame(FP, 0, 0, 35, -1, 0, 0);

    for (int f = 0; f < 10; f++) begin
      bus.alarm_cnt = 8'($urandom_range(0, FP));
      np = (($urandom % 4) == 0) ? FP - $urandom_range(1, 30) : FP;
      run_frame(np, $urandom_range(0, np), -1, $urandom_range(0, 255), -1, 0, 0);
    end

    bus.alarm_cnt = 8'd100;
    run_frame(FP, 130, -1, 40, -1, 1, 0);
    run_frame(FP, 130, -1, 41, -1, 0, 0);
    run_frame(FP, 130, -1, 42, -1, 0, 0);

    bus.enable = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(FP, 110, -1, 50, -1, 0, 0);

    // reset asserted mid-frame while in RUN
    bus.threshold_in = 8'd77;
    bus.cam_vsync = 1'b1;
    bus.diff_vsync = 1'b1;
    model_start(77);
    tick(3);
    chk_frame_state();
    bus.diff_href = 1'b1;
    bus.diff_clken = 1'b1;
    bus.diff_bit = 8'hFF;
    tick(20);
    rst_n = 1'b0;
    #2;
    chk_reset("async_rst");
    bus.diff_href = 1'b0;
    bus.diff_clken = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.diff_vsync = 1'b0;
    m_filled = 0;
    m_rot = 0;
    m_hold = 0;
    m_flag = 0;
    m_thr = 0;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk_reset("rst_release");
    run_frame(FP, 0, 0, 9, -1, 0, 0);

    tick(10);
    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
